// File: rtl/fiber_frame_defs.sv
// Frame header layout shared by the DDC fiber framer and the RX deframer.
// Header bit positions use the stream's bit-0-is-MSB numbering.
package fiber_frame_defs;

  localparam logic [15:0] FRAME_SYNC_WORD = 16'hEB90;
  localparam int          FRAME_ADDR_W    = 14;
  localparam int          FRAME_MAX_LEN   = 32768;

  localparam int HDR_SYNC_MSB = 0;
  localparam int HDR_SYNC_LSB = 15;
  localparam int HDR_WC_MSB   = 16;
  localparam int HDR_WC_LSB   = 23;
  localparam int HDR_SEQ_MSB  = 32;
  localparam int HDR_SEQ_LSB  = 47;
  localparam int HDR_LEN_MSB  = 48;
  localparam int HDR_LEN_LSB  = 63;

  // err_code bit positions, reported as {keep,seq,len,sync}
  localparam int ERR_SYNC = 0;
  localparam int ERR_LEN  = 1;
  localparam int ERR_SEQ  = 2;
  localparam int ERR_KEEP = 3;

endpackage

// File: rtl/fiber_rx_pack128.sv
// Packs 64-bit payload beats into 128-bit RAM words, high half first.
// A flush on a high-half beat writes that beat with a zero-filled low half.
module fiber_rx_pack128 #(
  parameter int ADDR_W = 14
) (
  input  logic              fiber_clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              beat_valid,
  input  logic [63:0]       beat_data,
  input  logic              flush,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [127:0]      ram_din
);

  logic              half_q;
  logic [63:0]       hi_q;
  logic [ADDR_W-1:0] next_addr_q;

  always_ff @(posedge fiber_clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q      <= 1'b0;
      hi_q        <= '0;
      next_addr_q <= '0;
      ram_wr      <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
    end else begin
      ram_wr <= 1'b0;
      if (clear) begin
        half_q      <= 1'b0;
        next_addr_q <= '0;
        ram_addr    <= '0;
      end else if (beat_valid) begin
        if (!half_q) begin
          hi_q <= beat_data;
          if (flush) begin
            ram_wr      <= 1'b1;
            ram_din     <= {beat_data, 64'h0};
            ram_addr    <= next_addr_q;
            next_addr_q <= next_addr_q + 1'b1;
          end else begin
            half_q <= 1'b1;
          end
        end else begin
          half_q      <= 1'b0;
          ram_wr      <= 1'b1;
          ram_din     <= {hi_q, beat_data};
          ram_addr    <= next_addr_q;
          next_addr_q <= next_addr_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fiber_rx_deframe_v1.sv
// Aurora RX deframer: header validation, payload packing to RAM, per-frame status.
//   state      | meaning
//   ST_IDLE    | waiting for a header beat
//   ST_PAYLOAD | good header seen, writing payload beats
//   ST_DROP    | frame rejected, discarding beats until tlast
module fiber_rx_deframe_v1
  import fiber_frame_defs::*;
#(
  parameter logic [15:0] SYNC_WORD = FRAME_SYNC_WORD,
  parameter int          ADDR_W    = FRAME_ADDR_W,
  parameter int          MAX_LEN   = FRAME_MAX_LEN
) (
  input  logic              fiber_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [0:63]       rx_tdata_i,
  input  logic              rx_tvalid_i,
  input  logic [0:7]        rx_tkeep_i,
  input  logic              rx_tlast_i,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [127:0]      ram_din,
  output logic [7:0]        wave_code,
  output logic [15:0]       frame_seq,
  output logic [15:0]       frame_len,
  output logic              frame_done,
  output logic              frame_err,
  output logic [3:0]        err_code,
  output logic [15:0]       good_cnt,
  output logic [15:0]       err_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_DROP    = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        seq_valid_q;
  logic        seq_err_q, seq_err_d;
  logic        keep_err_q, keep_err_d;

  logic [15:0] hdr_sync, hdr_seq, hdr_len;
  logic [7:0]  hdr_wc;
  logic        keep_bad, len_ok, seq_bad;

  logic        done_set, err_set, hdr_take;
  logic [3:0]  err_bits;
  logic        pk_clear, pk_valid, pk_flush;

  assign hdr_sync = rx_tdata_i[HDR_SYNC_MSB:HDR_SYNC_LSB];
  assign hdr_wc   = rx_tdata_i[HDR_WC_MSB:HDR_WC_LSB];
  assign hdr_seq  = rx_tdata_i[HDR_SEQ_MSB:HDR_SEQ_LSB];
  assign hdr_len  = rx_tdata_i[HDR_LEN_MSB:HDR_LEN_LSB];

  assign keep_bad = (rx_tkeep_i != 8'hFF);
  assign len_ok   = ({16'd0, hdr_len} <= MAX_LEN);
  // frame_seq holds the sequence number of the previous good header
  assign seq_bad  = seq_valid_q && (hdr_seq != frame_seq + 16'd1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seq_err_d  = seq_err_q;
    keep_err_d = keep_err_q;
    done_set   = 1'b0;
    err_set    = 1'b0;
    hdr_take   = 1'b0;
    err_bits   = 4'b0000;
    pk_clear   = 1'b0;
    pk_valid   = 1'b0;
    pk_flush   = 1'b0;

    if (!enable) begin
      state_d  = ST_IDLE;
      pk_clear = 1'b1;
    end else if (rx_tvalid_i) begin
      case (state_q)
        ST_IDLE: begin
          if (hdr_sync != SYNC_WORD || !len_ok) begin
            err_set            = 1'b1;
            err_bits[ERR_SYNC] = (hdr_sync != SYNC_WORD);
            err_bits[ERR_LEN]  = !len_ok;
            err_bits[ERR_KEEP] = keep_bad;
            state_d            = rx_tlast_i ? ST_IDLE : ST_DROP;
          end else begin
            hdr_take           = 1'b1;
            pk_clear           = 1'b1;
            cnt_d              = 16'd0;
            seq_err_d          = seq_bad;
            keep_err_d         = keep_bad;
            err_bits[ERR_SEQ]  = seq_bad;
            err_bits[ERR_KEEP] = keep_bad;
            if (rx_tlast_i) begin
              state_d = ST_IDLE;
              if (hdr_len == 16'd0 && !seq_bad && !keep_bad) begin
                done_set = 1'b1;
              end else begin
                err_set           = 1'b1;
                err_bits[ERR_LEN] = (hdr_len != 16'd0);
              end
            end else if (hdr_len == 16'd0) begin
              err_set           = 1'b1;
              err_bits[ERR_LEN] = 1'b1;
              state_d           = ST_DROP;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          pk_valid           = 1'b1;
          cnt_d              = cnt_q + 16'd1;
          keep_err_d         = keep_err_q | keep_bad;
          err_bits[ERR_KEEP] = keep_bad;
          if (rx_tlast_i) begin
            pk_flush = 1'b1;
            state_d  = ST_IDLE;
            if (cnt_d == frame_len && !seq_err_q && !keep_err_d) begin
              done_set = 1'b1;
            end else begin
              err_set           = 1'b1;
              err_bits[ERR_LEN] = (cnt_d != frame_len);
            end
          end else if (cnt_d == frame_len) begin
            pk_flush          = 1'b1;
            err_set           = 1'b1;
            err_bits[ERR_LEN] = 1'b1;
            state_d           = ST_DROP;
          end
        end
        ST_DROP: begin
          if (rx_tlast_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge fiber_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      seq_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      keep_err_q  <= 1'b0;
      wave_code   <= '0;
      frame_seq   <= '0;
      frame_len   <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= '0;
      good_cnt    <= '0;
      err_cnt     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seq_err_q  <= seq_err_d;
      keep_err_q <= keep_err_d;
      frame_done <= done_set;
      frame_err  <= err_set;
      if (hdr_take) begin
        wave_code   <= hdr_wc;
        frame_seq   <= hdr_seq;
        frame_len   <= hdr_len;
        seq_valid_q <= 1'b1;
      end
      if (done_set) err_code <= 4'b0000;
      else          err_code <= err_code | err_bits;
      if (done_set) good_cnt <= good_cnt + 16'd1;
      if (err_set)  err_cnt  <= err_cnt + 16'd1;
    end
  end

  fiber_rx_pack128 #(.ADDR_W(ADDR_W)) u_pack (
    .fiber_clk  (fiber_clk),
    .rst_n      (rst_n),
    .clear      (pk_clear),
    .beat_valid (pk_valid),
    .beat_data  (rx_tdata_i),
    .flush      (pk_flush),
    .ram_wr     (ram_wr),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din)
  );

endmodule

// File: tb/tb_fiber_rx_deframe_v1.sv
// Directed bench for fiber_rx_deframe_v1: frames driven beat by beat, RAM writes and pulses logged.
module tb_fiber_rx_deframe_v1;

  logic          fiber_clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [0:63]   rx_tdata_i;
  logic          rx_tvalid_i;
  logic [0:7]    rx_tkeep_i;
  logic          rx_tlast_i;
  logic          ram_wr;
  logic [13:0]   ram_addr;
  logic [127:0]  ram_din;
  logic [7:0]    wave_code;
  logic [15:0]   frame_seq, frame_len;
  logic          frame_done, frame_err;
  logic [3:0]    err_code;
  logic [15:0]   good_cnt, err_cnt;

  int checks = 0;
  int errors = 0;

  logic [13:0]  wq_addr[$];
  logic [127:0] wq_data[$];
  int n_done = 0, n_err = 0, n_both = 0, n_done_wr = 0;

  fiber_rx_deframe_v1 dut (
    .fiber_clk(fiber_clk), .rst_n(rst_n), .enable(enable),
    .rx_tdata_i(rx_tdata_i), .rx_tvalid_i(rx_tvalid_i), .rx_tkeep_i(rx_tkeep_i),
    .rx_tlast_i(rx_tlast_i), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din),
    .wave_code(wave_code), .frame_seq(frame_seq), .frame_len(frame_len),
    .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code),
    .good_cnt(good_cnt), .err_cnt(err_cnt)
  );

  always #5 fiber_clk = ~fiber_clk;

  always @(negedge fiber_clk) begin
    if (ram_wr) begin
      wq_addr.push_back(ram_addr);
      wq_data.push_back(ram_din);
    end
    if (frame_done) n_done++;
    if (frame_err) n_err++;
    if (frame_done && frame_err) n_both++;
    if (frame_done && ram_wr) n_done_wr++;
  end

  function automatic logic [63:0] hdr(input logic [15:0] s, input logic [7:0] wc,
                                      input logic [15:0] sq, input logic [15:0] ln);
    return {s, wc, 8'h00, sq, ln};
  endfunction

  function automatic logic [63:0] pat(input logic [7:0] tag, input int i);
    return {tag, 8'(i), 48'h0123_4567_89AB};
  endfunction

  function automatic logic [127:0] wdata(input int i);
    return (wq_data.size() > i) ? wq_data[i] : 'x;
  endfunction

  function automatic logic [13:0] waddr(input int i);
    return (wq_addr.size() > i) ? wq_addr[i] : 'x;
  endfunction

  task automatic clear_mon();
    wq_addr.delete();
    wq_data.delete();
    n_done = 0; n_err = 0; n_both = 0; n_done_wr = 0;
  endtask

  task automatic beat(input logic [63:0] d, input logic last, input logic [7:0] keep);
    @(negedge fiber_clk);
    rx_tdata_i  = d;
    rx_tvalid_i = 1'b1;
    rx_tlast_i  = last;
    rx_tkeep_i  = keep;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge fiber_clk);
      rx_tvalid_i = 1'b0;
      rx_tlast_i  = 1'b0;
    end
  endtask

  // payload beats are tagged with the low byte of seq; tlast on the final beat
  task automatic send_frame(input logic [15:0] s, input logic [7:0] wc, input logic [15:0] sq,
                            input logic [15:0] ln, input int n, input bit hdr_last,
                            input int bad_keep);
    clear_mon();
    beat(hdr(s, wc, sq, ln), hdr_last, 8'hFF);
    if (!hdr_last)
      for (int i = 0; i < n; i++)
        beat(pat(sq[7:0], i), (i == n - 1), (i == bad_keep) ? 8'h0F : 8'hFF);
    idle(3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; rx_tdata_i = '0; rx_tvalid_i = 1'b0;
    rx_tkeep_i = 8'hFF; rx_tlast_i = 1'b0;
    repeat (3) @(negedge fiber_clk);
    checks++;
    if ({ram_wr, ram_addr, ram_din, wave_code, frame_seq, frame_len, frame_done, frame_err,
         err_code, good_cnt, err_cnt} !== '0) begin
      errors++; $display("FAIL reset_outputs got wr=%b addr=%h good=%h err=%h code=%b exp all 0",
                         ram_wr, ram_addr, good_cnt, err_cnt, err_code);
    end
    rst_n = 1'b1;
    enable = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    send_frame(16'hEB90, 8'h01, 16'd0, 16'd4, 4, 1'b0, -1);
    checks++; if (wq_data.size() !== 2) begin errors++; $display("FAIL basic_nwr got %0d exp 2", wq_data.size()); end
    checks++; if (waddr(0) !== 14'd0 || wdata(0) !== {pat(8'h00,0), pat(8'h00,1)}) begin errors++; $display("FAIL basic_wr0 got %h@%h", wdata(0), waddr(0)); end
    checks++; if (waddr(1) !== 14'd1 || wdata(1) !== {pat(8'h00,2), pat(8'h00,3)}) begin errors++; $display("FAIL basic_wr1 got %h@%h", wdata(1), waddr(1)); end
    checks++; if (n_done !== 1 || n_err !== 0) begin errors++; $display("FAIL basic_pulse got done=%0d err=%0d exp 1 0", n_done, n_err); end
    checks++; if (n_done_wr !== 1) begin errors++; $display("FAIL basic_done_with_wr got %0d exp 1", n_done_wr); end
    checks++; if (wave_code !== 8'h01 || frame_len !== 16'd4 || frame_seq !== 16'd0) begin errors++; $display("FAIL basic_fields got wc=%h len=%0d seq=%0d", wave_code, frame_len, frame_seq); end
    checks++; if (good_cnt !== 16'd1 || err_code !== 4'b0000) begin errors++; $display("FAIL basic_status got good=%0d code=%b exp 1 0000", good_cnt, err_code); end
  endtask

  task automatic test_odd_len();
    send_frame(16'hEB90, 8'h22, 16'd1, 16'd3, 3, 1'b0, -1);
    checks++; if (wq_data.size() !== 2) begin errors++; $display("FAIL odd_nwr got %0d exp 2", wq_data.size()); end
    checks++; if (waddr(1) !== 14'd1 || wdata(1) !== {pat(8'h01,2), 64'h0}) begin errors++; $display("FAIL odd_zero_fill got %h@%h", wdata(1), waddr(1)); end
    checks++; if (n_done !== 1 || n_done_wr !== 1 || good_cnt !== 16'd2) begin errors++; $display("FAIL odd_done got done=%0d dw=%0d good=%0d", n_done, n_done_wr, good_cnt); end
  endtask

  task automatic test_bad_sync();
    send_frame(16'h1234, 8'h33, 16'd2, 16'd4, 5, 1'b0, -1);
    checks++; if (wq_data.size() !== 0) begin errors++; $display("FAIL sync_nwr got %0d exp 0", wq_data.size()); end
    checks++; if (n_err !== 1 || n_done !== 0 || err_code !== 4'b0001 || err_cnt !== 16'd1) begin errors++; $display("FAIL sync_err got err=%0d done=%0d code=%b cnt=%0d", n_err, n_done, err_code, err_cnt); end
    send_frame(16'hEB90, 8'h34, 16'd2, 16'd2, 2, 1'b0, -1);
    checks++; if (n_done !== 1 || err_code !== 4'b0000 || good_cnt !== 16'd3 || wave_code !== 8'h34) begin errors++; $display("FAIL sync_recover got done=%0d code=%b good=%0d wc=%h", n_done, err_code, good_cnt, wave_code); end
  endtask

  task automatic test_len_errors();
    send_frame(16'hEB90, 8'h40, 16'd3, 16'd4, 2, 1'b0, -1);
    checks++; if (wq_data.size() !== 1 || wdata(0) !== {pat(8'h03,0), pat(8'h03,1)}) begin errors++; $display("FAIL short_wr got n=%0d d=%h", wq_data.size(), wdata(0)); end
    checks++; if (n_err !== 1 || n_done !== 0 || err_code !== 4'b0010 || err_cnt !== 16'd2) begin errors++; $display("FAIL short_err got err=%0d done=%0d code=%b cnt=%0d", n_err, n_done, err_code, err_cnt); end
    send_frame(16'hEB90, 8'h41, 16'd4, 16'd4, 6, 1'b0, -1);
    checks++; if (wq_data.size() !== 2 || wdata(1) !== {pat(8'h04,2), pat(8'h04,3)}) begin errors++; $display("FAIL long_wr got n=%0d d=%h", wq_data.size(), wdata(1)); end
    checks++; if (n_err !== 1 || n_done !== 0 || err_cnt !== 16'd3) begin errors++; $display("FAIL long_err got err=%0d done=%0d cnt=%0d", n_err, n_done, err_cnt); end
  endtask

  task automatic test_keep();
    send_frame(16'hEB90, 8'h50, 16'd5, 16'd2, 2, 1'b0, 1);
    checks++; if (wq_data.size() !== 1 || wdata(0) !== {pat(8'h05,0), pat(8'h05,1)}) begin errors++; $display("FAIL keep_wr got n=%0d d=%h", wq_data.size(), wdata(0)); end
    checks++; if (n_err !== 1 || n_done !== 0 || err_code !== 4'b1010 || err_cnt !== 16'd4) begin errors++; $display("FAIL keep_err got err=%0d done=%0d code=%b cnt=%0d", n_err, n_done, err_code, err_cnt); end
  endtask

  task automatic test_boundaries();
    send_frame(16'hEB90, 8'h60, 16'd6, 16'h8001, 0, 1'b1, -1);
    checks++; if (n_err !== 1 || wq_data.size() !== 0 || err_cnt !== 16'd5 || wave_code !== 8'h50) begin errors++; $display("FAIL maxlen_err got err=%0d nwr=%0d cnt=%0d wc=%h", n_err, wq_data.size(), err_cnt, wave_code); end
    send_frame(16'hEB90, 8'h61, 16'd6, 16'd0, 0, 1'b1, -1);
    checks++; if (n_done !== 1 || n_err !== 0 || err_code !== 4'b0000 || good_cnt !== 16'd4) begin errors++; $display("FAIL len0_done got done=%0d err=%0d code=%b good=%0d", n_done, n_err, err_code, good_cnt); end
    send_frame(16'hEB90, 8'h62, 16'd7, 16'd1, 1, 1'b0, -1);
    checks++; if (wq_data.size() !== 1 || waddr(0) !== 14'd0 || wdata(0) !== {pat(8'h07,0), 64'h0}) begin errors++; $display("FAIL len1_wr got n=%0d d=%h@%h", wq_data.size(), wdata(0), waddr(0)); end
    checks++; if (n_done_wr !== 1 || good_cnt !== 16'd5) begin errors++; $display("FAIL len1_done got dw=%0d good=%0d", n_done_wr, good_cnt); end
  endtask

  task automatic test_enable_abort();
    clear_mon();
    beat(hdr(16'hEB90, 8'h70, 16'd8, 16'd4), 1'b0, 8'hFF);
    for (int i = 0; i < 3; i++) beat(pat(8'h08, i), 1'b0, 8'hFF);
    @(negedge fiber_clk);
    enable = 1'b0;
    rx_tdata_i = pat(8'h08, 3);
    rx_tlast_i = 1'b1;
    @(negedge fiber_clk);
    rx_tdata_i = hdr(16'hEB90, 8'h7F, 16'd99, 16'd0);
    idle(1);
    enable = 1'b1;
    idle(2);
    checks++; if (wq_data.size() !== 1 || n_done !== 0 || n_err !== 0) begin errors++; $display("FAIL abort got nwr=%0d done=%0d err=%0d exp 1 0 0", wq_data.size(), n_done, n_err); end
    send_frame(16'hEB90, 8'h71, 16'd9, 16'd2, 2, 1'b0, -1);
    checks++; if (wq_data.size() !== 1 || waddr(0) !== 14'd0 || wdata(0) !== {pat(8'h09,0), pat(8'h09,1)}) begin errors++; $display("FAIL abort_next_wr got n=%0d d=%h@%h", wq_data.size(), wdata(0), waddr(0)); end
    checks++; if (n_done !== 1 || good_cnt !== 16'd6 || err_cnt !== 16'd5) begin errors++; $display("FAIL abort_next got done=%0d good=%0d err=%0d", n_done, good_cnt, err_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    beat(hdr(16'hEB90, 8'h80, 16'd10, 16'd4), 1'b0, 8'hFF);
    beat(pat(8'h0A, 0), 1'b0, 8'hFF);
    beat(pat(8'h0A, 1), 1'b0, 8'hFF);
    @(posedge fiber_clk);
    #2 rst_n = 1'b0;
    rx_tvalid_i = 1'b0;
    #1;
    checks++;
    if ({ram_wr, ram_addr, ram_din, wave_code, frame_seq, frame_len, frame_done, frame_err,
         err_code, good_cnt, err_cnt} !== '0) begin
      errors++; $display("FAIL async_reset got wr=%b wc=%h good=%0d err=%0d exp all 0",
                         ram_wr, wave_code, good_cnt, err_cnt);
    end
    @(negedge fiber_clk);
    rst_n = 1'b1;
    idle(1);
    send_frame(16'hEB90, 8'h81, 16'd100, 16'd2, 2, 1'b0, -1);
    checks++; if (n_done !== 1 || n_err !== 0 || err_code !== 4'b0000 || good_cnt !== 16'd1 || err_cnt !== 16'd0) begin errors++; $display("FAIL post_reset got done=%0d err=%0d code=%b good=%0d errc=%0d", n_done, n_err, err_code, good_cnt, err_cnt); end
  endtask

  task automatic test_seq();
    @(negedge fiber_clk);
    rst_n = 1'b0;
    @(negedge fiber_clk);
    rst_n = 1'b1;
    send_frame(16'hEB90, 8'h90, 16'd5, 16'd2, 2, 1'b0, -1);
    checks++; if (n_done !== 1 || n_err !== 0) begin errors++; $display("FAIL seq5 got done=%0d err=%0d exp 1 0", n_done, n_err); end
    send_frame(16'hEB90, 8'h91, 16'd7, 16'd2, 2, 1'b0, -1);
    checks++; if (wq_data.size() !== 1 || wdata(0) !== {pat(8'h07,0), pat(8'h07,1)}) begin errors++; $display("FAIL seq7_wr got n=%0d d=%h", wq_data.size(), wdata(0)); end
    checks++; if (n_err !== 1 || n_done !== 0 || err_code !== 4'b0100 || err_cnt !== 16'd1) begin errors++; $display("FAIL seq7_err got err=%0d done=%0d code=%b cnt=%0d", n_err, n_done, err_code, err_cnt); end
    send_frame(16'hEB90, 8'h92, 16'd8, 16'd2, 2, 1'b0, -1);
    checks++; if (n_done !== 1 || err_code !== 4'b0000 || good_cnt !== 16'd2 || frame_seq !== 16'd8) begin errors++; $display("FAIL seq8 got done=%0d code=%b good=%0d seq=%0d", n_done, err_code, good_cnt, frame_seq); end
  endtask

  task automatic test_exclusive();
    checks++; if (n_both !== 0) begin errors++; $display("FAIL done_err_overlap got %0d exp 0", n_both); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_len();
    test_bad_sync();
    test_len_errors();
    test_keep();
    test_boundaries();
    test_enable_abort();
    test_reset_mid();
    test_seq();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "bench timeout");
  end

endmodule
